// File: rtl/tone_wave_pkg.sv
// tone_wave_pkg: shared encodings, note table and increment helper for tone_wave_generator.
package tone_wave_pkg;
    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'b00,
        WAVE_SAW    = 2'b01,
        WAVE_TRI    = 2'b10,
        WAVE_PULSE  = 2'b11
    } wave_sel_e;

    localparam int NOTE_COUNT = 60;
    localparam int A4_IDX     = 33;

    // C2..B6 equal-tempered frequencies in milli-Hz
    localparam int NOTE_MHZ [NOTE_COUNT] = '{
          65406,   69296,   73416,   77782,   82407,   87307,
          92499,   97999,  103826,  110000,  116541,  123471,
         130813,  138591,  146832,  155563,  164814,  174614,
         184997,  195998,  207652,  220000,  233082,  246942,
         261626,  277183,  293665,  311127,  329628,  349228,
         369994,  391995,  415305,  440000,  466164,  493883,
         523251,  554365,  587330,  622254,  659255,  698456,
         739989,  783991,  830609,  880000,  932328,  987767,
        1046502, 1108731, 1174659, 1244508, 1318510, 1396913,
        1479978, 1567982, 1661219, 1760000, 1864655, 1975533
    };

    function automatic longint note_inc(int mhz, int phase_w, int clk_hz);
        longint den;
        den = longint'(clk_hz) * 1000;
        return ((longint'(mhz) << phase_w) * 2 + den) / (den * 2);
    endfunction
endpackage

// File: rtl/tone_wave_if.sv
// tone_wave_if: control and sample bundle between a controller and tone_wave_generator.
interface tone_wave_if #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 32
);
    logic               enable;
    logic               load;
    logic [5:0]         note;
    logic               use_direct;
    logic [PHASE_W-1:0] inc_direct;
    logic [1:0]         wave_sel;
    logic [DATA_W-1:0]  duty;
    logic [DATA_W-1:0]  wave_out;
    logic               cycle_start;
    logic               note_err;
    logic               active;

    modport master (
        output enable, load, note, use_direct, inc_direct, wave_sel, duty,
        input  wave_out, cycle_start, note_err, active
    );
    modport slave (
        input  enable, load, note, use_direct, inc_direct, wave_sel, duty,
        output wave_out, cycle_start, note_err, active
    );
endinterface

// File: rtl/tone_note_rom.sv
// tone_note_rom: note index to phase increment, out-of-range notes fall back to A4.
module tone_note_rom
    import tone_wave_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int CLK_HZ  = 25_000_000
) (
    input  logic [5:0]         note,
    output logic [PHASE_W-1:0] inc,
    output logic               bad
);
    logic [PHASE_W-1:0] rom [NOTE_COUNT];

    for (genvar i = 0; i < NOTE_COUNT; i++) begin : g_rom
        assign rom[i] = PHASE_W'(note_inc(NOTE_MHZ[i], PHASE_W, CLK_HZ));
    end

    assign bad = note >= 6'(NOTE_COUNT);
    assign inc = rom[bad ? 6'(A4_IDX) : note];
endmodule

// File: rtl/tone_wave_generator.sv
// tone_wave_generator: phase-accumulator tone source with period-boundary settings update.
module tone_wave_generator
    import tone_wave_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 32,
    parameter int CLK_HZ  = 25_000_000
) (
    input logic        clk,
    input logic        reset,
    tone_wave_if.slave bus
);
    typedef struct packed {
        logic [PHASE_W-1:0] inc;
        wave_sel_e          sel;
        logic [DATA_W-1:0]  duty;
    } settings_t;

    settings_t          act, pend, ld_set;
    logic               pend_valid, wrap_q, rom_bad, carry, wrap, apply;
    logic [PHASE_W-1:0] phase, phase_nxt, rom_inc;
    logic [DATA_W-1:0]  p, shape, dbl;

    tone_note_rom #(.PHASE_W(PHASE_W), .CLK_HZ(CLK_HZ)) u_rom (
        .note(bus.note),
        .inc (rom_inc),
        .bad (rom_bad)
    );

    assign ld_set = '{inc:  bus.use_direct ? bus.inc_direct : rom_inc,
                      sel:  wave_sel_e'(bus.wave_sel),
                      duty: bus.duty};
    assign {carry, phase_nxt} = {1'b0, phase} + {1'b0, act.inc};
    assign wrap  = bus.enable && carry;
    // A zero increment never wraps, so staged settings must be allowed through immediately.
    assign apply = wrap || act.inc == '0;
    assign p     = phase[PHASE_W-1 -: DATA_W];
    assign dbl   = {p[DATA_W-2:0], 1'b0};
    assign bus.active = act.inc != '0;

    always_comb
        shape = act.sel == WAVE_SQUARE ? (p[DATA_W-1] ? '0 : '1) :
                act.sel == WAVE_SAW    ? p :
                act.sel == WAVE_TRI    ? (p[DATA_W-1] ? ~dbl : dbl) :
                                         (p < act.duty ? '1 : '0);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            phase           <= '0;
            act             <= '0;
            pend            <= '0;
            pend_valid      <= 1'b0;
            wrap_q          <= 1'b0;
            bus.wave_out    <= '0;
            bus.cycle_start <= 1'b0;
            bus.note_err    <= 1'b0;
        end else begin
            if (bus.enable) phase <= phase_nxt;
            wrap_q          <= wrap;
            bus.cycle_start <= bus.enable && wrap_q;
            bus.wave_out    <= bus.enable && bus.active ? shape : '0;
            if (bus.load) bus.note_err <= !bus.use_direct && rom_bad;
            if (bus.load && apply) begin
                act        <= ld_set;
                pend_valid <= 1'b0;
            end else if (bus.load) begin
                pend       <= ld_set;
                pend_valid <= 1'b1;
            end else if (apply && pend_valid) begin
                act        <= pend;
                pend_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_tone_wave_generator.sv
// tb_tone_wave_generator: directed and random checks of tone_wave_generator against a cycle model.
module tb_tone_wave_generator;
    logic clk = 1'b0;
    logic reset, reset32;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    tone_wave_if #(.DATA_W(8),  .PHASE_W(8))  b8 ();
    tone_wave_if #(.DATA_W(32), .PHASE_W(32)) b32 ();

    tone_wave_generator #(.DATA_W(8), .PHASE_W(8)) dut8 (
        .clk(clk), .reset(reset), .bus(b8)
    );
    tone_wave_generator #(.DATA_W(32), .PHASE_W(32)) dut32 (
        .clk(clk), .reset(reset32), .bus(b32)
    );

    // Model of the 8-bit instance: settings as plain integers, phase modulo 256.
    int unsigned m_phase, m_inc, m_sel, m_duty, p_inc, p_sel, p_duty;
    bit          p_valid, m_err, m_wrapd;
    int unsigned e_wave;
    bit          e_cs;

    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned wave_of(int unsigned ph, int unsigned sel, int unsigned duty);
        case (sel)
            0: return ph < 128 ? 255 : 0;
            1: return ph;
            2: return ph < 128 ? 2 * ph : 511 - 2 * ph;
            default: return ph < duty ? 255 : 0;
        endcase
    endfunction

    task automatic m_reset();
        m_phase = 0; m_inc = 0; m_sel = 0; m_duty = 0;
        p_inc = 0; p_sel = 0; p_duty = 0; p_valid = 0;
        m_err = 0; m_wrapd = 0; e_wave = 0; e_cs = 0;
    endtask

    task automatic model_edge();
        int unsigned sum, li;
        bit          wr, ap, en;
        if (reset) begin
            m_reset();
            return;
        end
        en  = b8.enable;
        sum = m_phase + m_inc;
        wr  = en && sum > 255;
        ap  = wr || m_inc == 0;
        e_wave  = (en && m_inc != 0) ? wave_of(m_phase, m_sel, m_duty) : 0;
        e_cs    = en && m_wrapd;
        m_wrapd = wr;
        if (en) m_phase = sum % 256;
        // At 8 phase bits every note increment rounds to zero.
        li = b8.use_direct ? int'(b8.inc_direct) : 0;
        if (b8.load) begin
            m_err = !b8.use_direct && b8.note >= 60;
            if (ap) begin
                m_inc = li; m_sel = b8.wave_sel; m_duty = b8.duty; p_valid = 0;
            end else begin
                p_inc = li; p_sel = b8.wave_sel; p_duty = b8.duty; p_valid = 1;
            end
        end else if (ap && p_valid) begin
            m_inc = p_inc; m_sel = p_sel; m_duty = p_duty; p_valid = 0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("wave_out", b8.wave_out, e_wave);
        chk("cycle_start", b8.cycle_start, e_cs);
        chk("note_err", b8.note_err, m_err);
        chk("active", b8.active, m_inc != 0);
    endtask

    task automatic drive8(bit ld, bit ud, int inc, int nt, int sel, int duty);
        b8.load = ld; b8.use_direct = ud; b8.inc_direct = 8'(inc);
        b8.note = 6'(nt); b8.wave_sel = 2'(sel); b8.duty = 8'(duty);
    endtask

    task automatic load8(int inc, int sel, int duty);
        drive8(1, 1, inc, 0, sel, duty);
        cyc();
        b8.load = 0;
    endtask

    task automatic load32(int nt);
        b32.load = 1; b32.note = 6'(nt);
        @(posedge clk); model_edge(); #1;
        b32.load = 0;
    endtask

    task automatic step32(string tag, longint exp);
        logic [31:0] w1, w2, d;
        repeat (2) begin @(posedge clk); model_edge(); end
        #1 w1 = b32.wave_out;
        @(posedge clk); model_edge();
        #1 w2 = b32.wave_out;
        d = w2 - w1;
        chk({tag, "_first"}, w1, exp);
        chk({tag, "_step"}, d, exp);
    endtask

    initial begin
        reset = 1; reset32 = 1;
        b8.enable = 1; drive8(0, 1, 0, 0, 0, 0);
        b32.enable = 1; b32.load = 0; b32.note = 0; b32.use_direct = 0;
        b32.inc_direct = 0; b32.wave_sel = 2'b01; b32.duty = 0;
        m_reset();
        repeat (2) cyc();
        reset = 0;
        // Idle after reset: nothing may toggle before a load.
        repeat (4) cyc();
        chk("idle_wave", b8.wave_out, 0);

        load8(16, 1, 0);
        repeat (40) cyc();
        load8(16, 0, 0);
        repeat (40) cyc();
        load8(16, 3, 64);
        repeat (40) cyc();
        load8(16, 2, 0);
        repeat (40) cyc();

        // Mid-period speed change: every period must still start at 0.
        load8(16, 1, 0);
        repeat (37) cyc();
        load8(32, 1, 0);
        repeat (40) begin
            cyc();
            if (b8.cycle_start) chk("start_at_zero", b8.wave_out, 0);
        end

        b8.enable = 0;
        repeat (8) cyc();
        b8.enable = 1;
        repeat (20) cyc();

        // Asynchronous reset with a staged load outstanding.
        load8(64, 0, 0);
        #2 reset = 1;
        #1;
        chk("rst_wave", b8.wave_out, 0);
        chk("rst_active", b8.active, 0);
        chk("rst_cs", b8.cycle_start, 0);
        m_reset();
        repeat (2) cyc();
        reset = 0;
        repeat (12) begin
            cyc();
            chk("post_rst_wave", b8.wave_out, 0);
        end
        load8(16, 1, 0);
        repeat (20) cyc();

        // Random loads, notes and enable gaps.
        repeat (700) begin
            b8.enable = $urandom_range(0, 19) != 0;
            if ($urandom_range(0, 11) == 0)
                drive8(1, $urandom_range(0, 9) != 0, $urandom_range(0, 64), $urandom_range(0, 63),
                       $urandom_range(0, 3), $urandom_range(0, 255));
            else
                b8.load = 0;
            cyc();
        end
        b8.load = 0;

        // Note-table path at the default widths and clock.
        reset32 = 0;
        load32(33);
        chk("a4_err", b32.note_err, 0);
        chk("a4_active", b32.active, 1);
        step32("a4", 75591);
        reset32 = 1;
        #1 chk("rst32_wave", b32.wave_out, 0);
        @(posedge clk); model_edge(); #1;
        reset32 = 0;
        load32(62);
        chk("bad_note_err", b32.note_err, 1);
        step32("bad_note", 75591);
        load32(0);
        chk("err_cleared", b32.note_err, 0);
        reset32 = 1;
        @(posedge clk); model_edge(); #1;
        reset32 = 0;
        load32(0);
        chk("c2_err", b32.note_err, 0);
        step32("c2", 11237);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tone_wave_generator.md
# tone_wave_generator

Parametrised, single-clock tone source for the signal-generator datapath. A phase accumulator replaces the derived-clock square-wave divider. It produces square, sawtooth, triangle or variable-duty pulse waveforms of DATA_W bits from either a 60-entry note table (C2–B6) or a direct phase increment. Frequency and waveform changes are staged and applied only at a period boundary, so the output is glitch-free. The output feeds the DAC/output mux in place of the fixed 8-bit square generator.

## Interface
- DATA_W, 8: output sample width (≥4)
- PHASE_W, 32: phase accumulator width (≥DATA_W)
- CLK_HZ, 25_000_000: clk frequency used to build note increments
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- enable  in  1  1 = accumulate; 0 = phase holds, wave_out forced to 0
- load  in  1  single-cycle strobe; captures note, use_direct, inc_direct, wave_sel, duty
- note  in  6  note index 0..59 (C2..B6, 12 per octave)
- use_direct  in  1  1 = use inc_direct instead of note table
- inc_direct  in  PHASE_W  direct phase increment
- wave_sel  in  2  00 square, 01 saw, 10 triangle, 11 pulse
- duty  in  DATA_W  pulse threshold
- wave_out  out  DATA_W  registered sample
- cycle_start  out  1  one-cycle pulse aligned with first sample of each period
- note_err  out  1  last load carried note ≥60
- active  out  1  active increment ≠ 0

## Operation
- Settings registers: pending (captured on load) and active (drives datapath). pend_valid is set by load and cleared when pending is applied.
- Apply rule: on a cycle where the accumulator wraps (carry out), or any cycle where active increment = 0, active ← pending if pend_valid. A load in that same cycle bypasses pending: its values become active directly.
- Increment = inc_direct if use_direct, else ROM[note]. ROM[i] = round(f_i·2^PHASE_W / CLK_HZ). A4 at the defaults = 75591.
- Note ≥60: increment = ROM[33] (A4), and note_err ← 1. A load with a valid note or use_direct=1 clears note_err.
- Accumulator: phase ← phase + inc mod 2^PHASE_W when enable. The wrap flag is the carry out.
- Sample p = phase[PHASE_W-1 -: DATA_W]; MAX = 2^DATA_W−1.
- Square: MAX if p MSB = 0, else 0.
- Saw: p.
- Triangle: (p<<1) truncated if MSB = 0, else ~(p<<1) truncated.
- Pulse: MAX if p < duty, else 0. duty = 0 gives constant 0.
- Reset values: phase 0, active and pending increments 0, pend_valid 0, wave_sel 00, duty 0, wave_out 0, cycle_start 0, note_err 0, active 0.
- Reset mid-period discards pending settings. After reset release, a load is required before any output toggles.
- enable low does not block applying pending settings while active increment = 0. With a nonzero increment, application waits for the next wrap after enable returns.

## Timing
- Latency is 1 cycle from phase register to wave_out.
- cycle_start rises in the same cycle as the first wave_out computed from post-wrap phase.
- Load to first effect: with active increment 0, the new increment is active the cycle after load, phase first advances the next edge, and wave_out changes 1 cycle later. Otherwise it takes effect at the next wrap.
- Period = 2^PHASE_W / inc cycles (exact when inc is a power of two).
- Back-to-back loads: the last one before the wrap wins.

## Structure
- Package tone_wave_pkg holds:
  - wave_sel encodings;
  - the 60-entry note frequency table in milli-Hz;
  - the A4 default index;
  - an elaboration function computing the increment from (mHz, PHASE_W, CLK_HZ).
- Sub-module tone_note_rom: note index → increment plus an out-of-range flag. Purely combinational, constant table built from the package.

## Test plan
- PHASE_W=8, DATA_W=8, use_direct=1, inc_direct=16, saw, load once → wave_out steps 0,16,…,240 repeating every 16 cycles; cycle_start on each 0.
- Same setup, square → 8 cycles 255, then 8 cycles 0. Pulse with duty=64 → 4 cycles 255, then 12 cycles 0.
- Triangle, inc=16 → 0,32,…,224,255,223,…,31 repeating.
- Mid-period load inc=32 → increment changes only after the next wrap; no sample ever misses 0 at period start.
- Defaults, note=33 → phase step 75591. note=62 → note_err=1 and step 75591. A following load with note=0 → note_err=0 and step 11237.
- Reset asserted mid-period with a pending load → all outputs 0; pending lost; output stays 0 until a new load.
